seq_detector_flex: RTL and testbench

Parametrised serial bit-pattern detector: the successor to the fixed 4-bit Moore "1101" detector. Pattern width, default pattern, overlap mode and match-counter width are parameters. The pattern is also reloadable at run time. Serial data is sampled under an enable, the registered Moore output `o` flags each match, and a saturating counter tallies matches. It sits directly on a serial input stream, feeding status/interrupt logic.

---
 rtl/seq_detector_flex_pkg.sv | 22 ++
 rtl/seq_detector_flex_sat_counter.sv | 27 ++
 rtl/seq_detector_flex.sv | 78 +++++++
 tb/tb_seq_detector_flex.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seq_detector_flex_pkg.sv
// Shared constants and types for the flexible serial pattern detector.
package seq_det_pkg;

    // Default pattern of the original fixed detector (MSB is the oldest bit)
    localparam logic [3:0] PAT_1101 = 4'b1101;

    // Overlap-mode selectors
    localparam bit OVL_ON  = 1'b1;
    localparam bit OVL_OFF = 1'b0;

    // Widest supported pattern; the fill counter is sized so that it can hold 0..MAX_PAT_W
    localparam int MAX_PAT_W = 16;
    localparam int FILL_W    = $clog2(MAX_PAT_W + 1);

    typedef logic [FILL_W-1:0] fill_t;

    // Advance the fill counter by one, sticking at the given ceiling
    function automatic fill_t fill_advance(input fill_t cur, input fill_t ceiling);
        fill_advance = (cur >= ceiling) ? ceiling : fill_t'(cur + fill_t'(1));
    endfunction

endpackage

// File: rtl/seq_detector_flex_sat_counter.sv
// Saturating event counter with a synchronous clear; clear beats increment.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] COUNT_MAX = '1;

    // Count increments, parking at all-ones so a long burst never wraps to a small value
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != COUNT_MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_flex.sv
// Serial bit-pattern detector: reloadable pattern, optional overlap,
// registered Moore match flag and a saturating match tally.
module seq_detector_flex
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = PAT_1101,
    parameter bit               OVERLAP = OVL_ON,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i,
    input  logic             en,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             clr,
    output logic             o,
    output logic [CNT_W-1:0] match_count
);

    localparam fill_t FILL_FULL = fill_t'(PAT_W);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] pat;
    fill_t            fill;
    logic             m;

    logic [PAT_W-1:0] next_hist;
    fill_t            next_fill;
    logic             hit;
    logic             sample;

    // Candidate history/fill for the current bit; the fill check keeps a
    // partly-filled (zeroed) history from matching, even an all-zero pattern
    always_comb begin
        next_hist = {hist[PAT_W-2:0], i};
        next_fill = fill_advance(fill, FILL_FULL);
        hit       = (next_hist == pat) && (next_fill == FILL_FULL);
        sample    = en && !pat_load;
    end

    // Detector state: reset, then pattern reload (drops any concurrent bit), then enabled sampling
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            hist <= '0;
            fill <= '0;
            pat  <= PATTERN;
            m    <= 1'b0;
        end else if (pat_load) begin
            pat  <= pat_in;
            fill <= '0;
            m    <= 1'b0;
        end else if (en) begin
            m <= hit;
            if (hit && !OVERLAP) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= next_hist;
                fill <= next_fill;
            end
        end
    end

    assign o = m;

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (clr),
        .inc   (sample && hit),
        .count (match_count)
    );

endmodule

// File: tb/tb_seq_detector_flex.sv
// Directed bench for seq_detector_flex: three instances (default, no-overlap,
// 2-bit counter) share one input stream and are checked against hand-derived values.
module tb_seq_detector_flex;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       i = 1'b0;
    logic       en = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       clr = 1'b0;

    logic       o_a, o_b, o_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    seq_detector_flex dut_a (
        .clk(clk), .n_rst(n_rst), .i(i), .en(en), .pat_load(pat_load),
        .pat_in(pat_in), .clr(clr), .o(o_a), .match_count(cnt_a)
    );

    seq_detector_flex #(.OVERLAP(1'b0)) dut_b (
        .clk(clk), .n_rst(n_rst), .i(i), .en(en), .pat_load(pat_load),
        .pat_in(pat_in), .clr(clr), .o(o_b), .match_count(cnt_b)
    );

    seq_detector_flex #(.CNT_W(2)) dut_c (
        .clk(clk), .n_rst(n_rst), .i(i), .en(en), .pat_load(pat_load),
        .pat_in(pat_in), .clr(clr), .o(o_c), .match_count(cnt_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One enabled sample of bit b
    task automatic samp(input logic b);
        i  = b;
        en = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        en    = 1'b0;
        tick();
        n_rst = 1'b1;
    endtask

    logic [6:0] s1_bits;
    logic [6:0] s1_oa;
    logic [6:0] s1_ob;

    initial begin
        s1_bits = 7'b1101101;
        s1_oa   = 7'b0001001;
        s1_ob   = 7'b0001000;

        // Reset state, with junk on the data inputs
        i = 1'b1;
        en = 1'b1;
        clr = 1'b0;
        tick();
        tick();
        chk("rst_o_a", o_a, 0);
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_o_b", o_b, 0);
        n_rst = 1'b1;
        en = 1'b0;

        // Stream 1,1,0,1,1,0,1: overlap matches twice, non-overlap once
        for (int k = 6; k >= 0; k--) begin
            samp(s1_bits[k]);
            chk($sformatf("s1_o_a_bit%0d", 7 - k), o_a, s1_oa[k]);
            chk($sformatf("s1_o_b_bit%0d", 7 - k), o_b, s1_ob[k]);
        end
        chk("s1_cnt_a", cnt_a, 2);
        chk("s1_cnt_b", cnt_b, 1);
        chk("s1_cnt_c", cnt_c, 2);

        // Partial 1,1,0,0 then reset mid-stream, then 1,1,0,1
        do_reset();
        samp(1'b1); chk("s3_o_1", o_a, 0);
        samp(1'b1); chk("s3_o_2", o_a, 0);
        samp(1'b0); chk("s3_o_3", o_a, 0);
        samp(1'b0); chk("s3_o_4", o_a, 0);
        do_reset();
        chk("s3_rst_cnt", cnt_a, 0);
        samp(1'b1); chk("s3_o_5", o_a, 0);
        samp(1'b1); chk("s3_o_6", o_a, 0);
        samp(1'b0); chk("s3_o_7", o_a, 0);
        samp(1'b1); chk("s3_o_8", o_a, 1);
        chk("s3_cnt", cnt_a, 1);

        // 1,1,0 then en=0 for 5 cycles with i toggling, then 1
        do_reset();
        samp(1'b1);
        samp(1'b1);
        samp(1'b0);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i = ~i;
            tick();
            chk($sformatf("s4_gap_o_%0d", k), o_a, 0);
        end
        samp(1'b1);
        chk("s4_match_o", o_a, 1);
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i = ~i;
            tick();
            chk($sformatf("s4_hold_o_%0d", k), o_a, 1);
        end
        chk("s4_cnt", cnt_a, 1);

        // Load an all-zero pattern; a partial fill must not match
        en = 1'b0;
        pat_in = 4'b0000;
        pat_load = 1'b1;
        tick();
        pat_load = 1'b0;
        chk("s5_load_o", o_a, 0);
        samp(1'b0); chk("s5_z1", o_a, 0);
        samp(1'b0); chk("s5_z2", o_a, 0);
        samp(1'b0); chk("s5_z3", o_a, 0);
        samp(1'b0); chk("s5_z4", o_a, 1);
        chk("s5_cnt", cnt_a, 2);
        // Reload with a simultaneous enabled 0: that bit must be discarded
        i = 1'b0;
        en = 1'b1;
        pat_load = 1'b1;
        tick();
        pat_load = 1'b0;
        chk("s5_reload_o", o_a, 0);
        samp(1'b0); chk("s5_r1", o_a, 0);
        samp(1'b0); chk("s5_r2", o_a, 0);
        samp(1'b0); chk("s5_r3", o_a, 0);
        samp(1'b0); chk("s5_r4", o_a, 1);
        chk("s5_cnt2", cnt_a, 3);

        // Pattern 1111, nine 1s = six overlapping matches; 2-bit counter saturates
        do_reset();
        pat_in = 4'b1111;
        pat_load = 1'b1;
        tick();
        pat_load = 1'b0;
        samp(1'b1);
        samp(1'b1);
        samp(1'b1); chk("s6_o_c_3", o_c, 0);
        samp(1'b1); chk("s6_o_c_4", o_c, 1); chk("s6_cnt_c_4", cnt_c, 1);
        samp(1'b1); chk("s6_o_c_5", o_c, 1); chk("s6_cnt_c_5", cnt_c, 2);
        samp(1'b1); chk("s6_cnt_c_6", cnt_c, 3);
        samp(1'b1);
        samp(1'b1);
        samp(1'b1);
        chk("s6_cnt_c_sat", cnt_c, 3);
        chk("s6_cnt_a", cnt_a, 6);
        chk("s6_cnt_b", cnt_b, 2);
        // clr together with a match leaves the count at zero
        clr = 1'b1;
        samp(1'b1);
        clr = 1'b0;
        chk("s6_clr_o_c", o_c, 1);
        chk("s6_clr_cnt_c", cnt_c, 0);
        chk("s6_clr_cnt_a", cnt_a, 0);
        samp(1'b1);
        chk("s6_after_clr_cnt_c", cnt_c, 1);
        en = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
